// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline register: state encoding and default payload width.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HALF  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    localparam int PIPE_WIDTH = 32;

endpackage

// File: rtl/pipe_skid_reg_ce_reg.sv
// Clock-enabled register slice with asynchronous clear; one instance per storage entry.
module ce_reg #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CE,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            Q <= '0;
        else if (CE)
            Q <= D;
    end

endmodule

// File: rtl/pipe_skid_reg.sv
// Elastic valid/ready pipeline register with a one-entry skid buffer between processor stages.
// Optional stall counter on STALL_CNT is built when PIPE_STALL_CNT_EN is defined.
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int WIDTH = PIPE_WIDTH
`ifdef PIPE_STALL_CNT_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             FLUSH,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] IN_DATA,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] OUT_DATA
`ifdef PIPE_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0] STALL_CNT
`endif
);

    state_t           state;
    logic             accept;
    logic             emit;
    logic             main_ce;
    logic             skid_ce;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;

    // IN_READY depends only on local state and FLUSH/RST, never on OUT_READY.
    assign IN_READY  = (state != ST_FULL) & ~FLUSH & ~RST;
    assign OUT_VALID = (state != ST_EMPTY);
    assign OUT_DATA  = main_q;

    assign accept = IN_VALID & IN_READY;
    assign emit   = OUT_VALID & OUT_READY;

    always_comb begin
        main_ce = 1'b0;
        skid_ce = 1'b0;
        main_d  = IN_DATA;
        case (state)
            ST_EMPTY: main_ce = accept;
            ST_HALF: begin
                main_ce = accept & emit;
                skid_ce = accept & ~emit;
            end
            ST_FULL: begin
                main_ce = emit & ~FLUSH;
                main_d  = skid_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= ST_EMPTY;
        end else if (FLUSH) begin
            state <= ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: if (accept) state <= ST_HALF;
                ST_HALF: begin
                    if (accept & ~emit)
                        state <= ST_FULL;
                    else if (~accept & emit)
                        state <= ST_EMPTY;
                end
                ST_FULL: if (emit) state <= ST_HALF;
                default: state <= ST_EMPTY;
            endcase
        end
    end

    ce_reg #(.WIDTH(WIDTH)) u_main (
        .CLK (CLK),
        .RST (RST),
        .CE  (main_ce),
        .D   (main_d),
        .Q   (main_q)
    );

    ce_reg #(.WIDTH(WIDTH)) u_skid (
        .CLK (CLK),
        .RST (RST),
        .CE  (skid_ce),
        .D   (IN_DATA),
        .Q   (skid_q)
    );

`ifdef PIPE_STALL_CNT_EN
    // Saturating count of cycles the head entry waits on downstream; FLUSH leaves it alone.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            STALL_CNT <= '0;
        else if (OUT_VALID & ~OUT_READY & (STALL_CNT != {CNT_W{1'b1}}))
            STALL_CNT <= STALL_CNT + {{(CNT_W-1){1'b0}}, 1'b1};
    end
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed self-checking bench for pipe_skid_reg; stall counter scenarios run when PIPE_STALL_CNT_EN is defined.
module tb_pipe_skid_reg;

    localparam int W = 32;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         FLUSH = 1'b0;
    logic         IN_VALID = 1'b0;
    logic         IN_READY;
    logic [W-1:0] IN_DATA = '0;
    logic         OUT_VALID;
    logic         OUT_READY = 1'b0;
    logic [W-1:0] OUT_DATA;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

`ifdef PIPE_STALL_CNT_EN
    logic [15:0]  STALL_CNT;
    logic         in_ready3;
    logic         out_valid3;
    logic [W-1:0] out_data3;
    logic [2:0]   stall_cnt3;

    pipe_skid_reg #(.WIDTH(W), .CNT_W(16)) dut (
        .CLK(CLK), .RST(RST), .FLUSH(FLUSH),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_DATA(IN_DATA),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA),
        .STALL_CNT(STALL_CNT)
    );

    pipe_skid_reg #(.WIDTH(W), .CNT_W(3)) dut3 (
        .CLK(CLK), .RST(RST), .FLUSH(FLUSH),
        .IN_VALID(IN_VALID), .IN_READY(in_ready3), .IN_DATA(IN_DATA),
        .OUT_VALID(out_valid3), .OUT_READY(OUT_READY), .OUT_DATA(out_data3),
        .STALL_CNT(stall_cnt3)
    );
`else
    pipe_skid_reg #(.WIDTH(W)) dut (
        .CLK(CLK), .RST(RST), .FLUSH(FLUSH),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_DATA(IN_DATA),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA)
    );
`endif

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (OUT_VALID !== 1'b0 || OUT_DATA !== 32'h0 || IN_READY !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold got v=%0b d=%0h r=%0b exp v=0 d=0 r=0", OUT_VALID, OUT_DATA, IN_READY);
        end
        step();
        step();
        RST = 1'b0;
        #1;
        checks++;
        if (IN_READY !== 1'b1 || OUT_VALID !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got r=%0b v=%0b exp r=1 v=0", IN_READY, OUT_VALID);
        end
    endtask

    task automatic test_stream();
        IN_VALID  = 1'b1;
        OUT_READY = 1'b1;
        for (int i = 0; i < 3; i++) begin
            IN_DATA = 32'h10 + i;
            checks++;
            if (IN_READY !== 1'b1) begin
                errors++;
                $display("FAIL stream_ready%0d got %0b exp 1", i, IN_READY);
            end
            step();
            checks++;
            if (OUT_VALID !== 1'b1 || OUT_DATA !== 32'h10 + i) begin
                errors++;
                $display("FAIL stream_data%0d got v=%0b d=%0h exp v=1 d=%0h", i, OUT_VALID, OUT_DATA, 32'h10 + i);
            end
        end
        IN_VALID = 1'b0;
        step();
        checks++;
        if (OUT_VALID !== 1'b0) begin
            errors++;
            $display("FAIL stream_empty got v=%0b exp 0", OUT_VALID);
        end
    endtask

    task automatic test_fill();
        OUT_READY = 1'b0;
        IN_VALID  = 1'b1;
        IN_DATA   = 32'hA0;
        step();
        checks++;
        if (OUT_VALID !== 1'b1 || OUT_DATA !== 32'hA0 || IN_READY !== 1'b1) begin
            errors++;
            $display("FAIL fill_half got v=%0b d=%0h r=%0b exp v=1 d=a0 r=1", OUT_VALID, OUT_DATA, IN_READY);
        end
        IN_DATA = 32'hA1;
        step();
        checks++;
        if (OUT_DATA !== 32'hA0 || IN_READY !== 1'b0) begin
            errors++;
            $display("FAIL fill_full got d=%0h r=%0b exp d=a0 r=0", OUT_DATA, IN_READY);
        end
        IN_DATA = 32'hA2;
        step();
        checks++;
        if (OUT_VALID !== 1'b1 || OUT_DATA !== 32'hA0 || IN_READY !== 1'b0) begin
            errors++;
            $display("FAIL fill_hold got v=%0b d=%0h r=%0b exp v=1 d=a0 r=0", OUT_VALID, OUT_DATA, IN_READY);
        end
    endtask

    task automatic test_drain();
        OUT_READY = 1'b1;
        checks++;
        if (OUT_DATA !== 32'hA0) begin
            errors++;
            $display("FAIL drain_0 got %0h exp a0", OUT_DATA);
        end
        step();
        checks++;
        if (OUT_VALID !== 1'b1 || OUT_DATA !== 32'hA1 || IN_READY !== 1'b1) begin
            errors++;
            $display("FAIL drain_1 got v=%0b d=%0h r=%0b exp v=1 d=a1 r=1", OUT_VALID, OUT_DATA, IN_READY);
        end
        step();
        checks++;
        if (OUT_VALID !== 1'b1 || OUT_DATA !== 32'hA2) begin
            errors++;
            $display("FAIL drain_2 got v=%0b d=%0h exp v=1 d=a2", OUT_VALID, OUT_DATA);
        end
        IN_VALID = 1'b0;
        step();
        checks++;
        if (OUT_VALID !== 1'b0) begin
            errors++;
            $display("FAIL drain_empty got v=%0b exp 0", OUT_VALID);
        end
    endtask

    task automatic test_flush();
        OUT_READY = 1'b0;
        IN_VALID  = 1'b1;
        IN_DATA   = 32'hC0;
        step();
        IN_DATA = 32'hC1;
        step();
        FLUSH   = 1'b1;
        IN_DATA = 32'hBB;
        #1;
        checks++;
        if (IN_READY !== 1'b0) begin
            errors++;
            $display("FAIL flush_ready got %0b exp 0", IN_READY);
        end
        step();
        FLUSH    = 1'b0;
        IN_VALID = 1'b0;
        checks++;
        if (OUT_VALID !== 1'b0) begin
            errors++;
            $display("FAIL flush_empty got v=%0b exp 0", OUT_VALID);
        end
        OUT_READY = 1'b1;
        step();
        step();
        checks++;
        if (OUT_VALID !== 1'b0 || IN_READY !== 1'b1) begin
            errors++;
            $display("FAIL flush_after got v=%0b r=%0b exp v=0 r=1", OUT_VALID, IN_READY);
        end
    endtask

    task automatic test_async_reset();
        OUT_READY = 1'b0;
        IN_VALID  = 1'b1;
        IN_DATA   = 32'h55;
        step();
        IN_VALID = 1'b0;
        checks++;
        if (OUT_VALID !== 1'b1 || OUT_DATA !== 32'h55) begin
            errors++;
            $display("FAIL arst_pre got v=%0b d=%0h exp v=1 d=55", OUT_VALID, OUT_DATA);
        end
        #3;
        RST = 1'b1;
        #1;
        checks++;
        if (OUT_VALID !== 1'b0 || OUT_DATA !== 32'h0 || IN_READY !== 1'b0) begin
            errors++;
            $display("FAIL arst_drop got v=%0b d=%0h r=%0b exp v=0 d=0 r=0", OUT_VALID, OUT_DATA, IN_READY);
        end
        step();
        RST = 1'b0;
        #1;
        checks++;
        if (OUT_VALID !== 1'b0 || IN_READY !== 1'b1) begin
            errors++;
            $display("FAIL arst_release got v=%0b r=%0b exp v=0 r=1", OUT_VALID, IN_READY);
        end
    endtask

`ifdef PIPE_STALL_CNT_EN
    task automatic test_stall_cnt();
        RST = 1'b1;
        step();
        RST = 1'b0;
        OUT_READY = 1'b0;
        IN_VALID  = 1'b1;
        IN_DATA   = 32'h77;
        step();
        IN_VALID = 1'b0;
        checks++;
        if (STALL_CNT !== 16'd0 || stall_cnt3 !== 3'd0) begin
            errors++;
            $display("FAIL stall_start got %0d/%0d exp 0/0", STALL_CNT, stall_cnt3);
        end
        for (int i = 0; i < 5; i++) step();
        checks++;
        if (STALL_CNT !== 16'd5 || stall_cnt3 !== 3'd5) begin
            errors++;
            $display("FAIL stall_5 got %0d/%0d exp 5/5", STALL_CNT, stall_cnt3);
        end
        for (int i = 0; i < 5; i++) step();
        checks++;
        if (STALL_CNT !== 16'd10 || stall_cnt3 !== 3'd7) begin
            errors++;
            $display("FAIL stall_sat got %0d/%0d exp 10/7", STALL_CNT, stall_cnt3);
        end
        FLUSH = 1'b1;
        step();
        FLUSH = 1'b0;
        step();
        checks++;
        if (STALL_CNT !== 16'd11 || stall_cnt3 !== 3'd7 || OUT_VALID !== 1'b0) begin
            errors++;
            $display("FAIL stall_flush got %0d/%0d v=%0b exp 11/7 v=0", STALL_CNT, stall_cnt3, OUT_VALID);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_fill();
        test_drain();
        test_flush();
        test_async_reset();
`ifdef PIPE_STALL_CNT_EN
        test_stall_cnt();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
